// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control bit positions, MEM-stage FSM
// encoding and the MEM/WB payload layout.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTL_W  = 5;

    // Bit positions inside the EX/MEM control bundle
    localparam int unsigned CTL_REGWRITE = 4;
    localparam int unsigned CTL_MEMTOREG = 3;
    localparam int unsigned CTL_BRANCH   = 2;
    localparam int unsigned CTL_MEMREAD  = 1;
    localparam int unsigned CTL_MEMWRITE = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // MEM/WB register contents; ctrl = {RegWrite, MemtoReg}
    typedef struct packed {
        logic [1:0]        ctrl;
        logic [WORD_W-1:0] read_data;
        logic [WORD_W-1:0] alu_result;
        logic [REG_W-1:0]  write_reg;
    } memwb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. When enable is low a bubble is inserted:
// control is cleared while the data fields hold their previous value.
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  memwb_t d,
    output memwb_t q
);

    // Load, bubble or clear the MEM/WB fields
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end else begin
            q.ctrl <= 2'b00;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolution, data memory access and the MEM/WB
// register. Define MEM_WAIT_EN to build the wait-state FSM that stretches
// each load/store over WAIT_CYCLES+1 cycles; otherwise stall is tied low.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTL_W-1:0]  bitsCtr,
    input  logic [WORD_W-1:0] resultadoAdd,
    input  logic              zero,
    input  logic [WORD_W-1:0] resultadoAlu,
    input  logic [WORD_W-1:0] rdata2out,
    input  logic [REG_W-1:0]  saidaMux5b,
    output logic              PCSrc,
    output logic [WORD_W-1:0] branchTarget,
    output logic              stall,
    output logic [1:0]        ctrlW,
    output logic [WORD_W-1:0] readDataW,
    output logic [WORD_W-1:0] aluResultW,
    output logic [REG_W-1:0]  writeRegW,
    output logic [WORD_W-1:0] ResultW
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     idx;
    logic              mem_op;
    logic [WORD_W-1:0] rd_data;
    memwb_t            wb_d;
    memwb_t            wb_q;
    logic              unused_addr;

    // Word index: byte offset dropped, upper bits wrap modulo DEPTH
    assign idx         = resultadoAlu[AW+1:2];
    assign unused_addr = ^{resultadoAlu[WORD_W-1:AW+2], resultadoAlu[1:0]};
    assign mem_op      = bitsCtr[CTL_MEMREAD] | bitsCtr[CTL_MEMWRITE];

`ifdef MEM_WAIT_EN
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Wait-state sequencer: arrival cycle plus WAIT_CYCLES-1 busy cycles stall, then DONE commits
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op && (WAIT_CYCLES != 0)) begin
                        cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        state <= (WAIT_CYCLES == 1) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Hold upstream while an access is still in progress
    assign stall = ((state == ST_IDLE) && mem_op && (WAIT_CYCLES != 0)) ||
                   (state == ST_BUSY);
`else
    localparam bit unused_wait = (WAIT_CYCLES != 0);

    assign stall = 1'b0;
`endif

    // Store commits once, in the completion (non-stalled) cycle
    always_ff @(posedge clk) begin
        if (!reset && !stall && bitsCtr[CTL_MEMWRITE]) begin
            mem[idx] <= rdata2out;
        end
    end

    assign rd_data      = mem[idx];
    assign PCSrc        = bitsCtr[CTL_BRANCH] & zero & ~stall;
    assign branchTarget = resultadoAdd;

    assign wb_d.ctrl       = {bitsCtr[CTL_REGWRITE], bitsCtr[CTL_MEMTOREG]};
    assign wb_d.read_data  = rd_data;
    assign wb_d.alu_result = resultadoAlu;
    assign wb_d.write_reg  = saidaMux5b;

    mem_wb_reg u_mem_wb (
        .clk    (clk),
        .reset  (reset),
        .enable (~stall),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign ctrlW      = wb_q.ctrl;
    assign readDataW  = wb_q.read_data;
    assign aluResultW = wb_q.alu_result;
    assign writeRegW  = wb_q.write_reg;
    assign ResultW    = wb_q.ctrl[0] ? wb_q.read_data : wb_q.alu_result;

endmodule
